// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD scan-out block.
// Holds the FSM encoding, geometry constants and the scan-order address map.
package lcd_pkg;

    localparam int IMG_W  = 8;
    localparam int PIX_N  = 64;
    localparam int SUM_W  = 14;
    localparam int ADDR_W = 6;
    localparam int PIX_W  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        SCAN    = 2'd2,
        REPORT  = 2'd3
    } lcd_state_t;

    // Column-major swaps the row and column fields of the index: (k%8)*8 + k/8.
    function automatic logic [ADDR_W-1:0] scan_addr(input logic [ADDR_W-1:0] k,
                                                    input logic col_major);
        return col_major ? {k[2:0], k[5:3]} : k;
    endfunction

endpackage

// File: rtl/lcd_scanout_if.sv
// Bus bundle between the image controller / panel side and lcd_scanout.
// master = environment side, slave = lcd_scanout.
interface lcd_scanout_if;
    import lcd_pkg::*;

    logic              IRAM_valid;
    logic [ADDR_W-1:0] IRAM_A;
    logic [PIX_W-1:0]  IRAM_D;
    logic              done;
    logic              scan_mode;
    logic              pix_ready;
    // Pixel stream: a beat transfers on any cycle with pix_valid=1 and pix_ready=1;
    // while pix_valid=1 and pix_ready=0, pix_data/sol/eof stay stable.
    logic              pix_valid;
    logic [PIX_W-1:0]  pix_data;
    logic              sol;
    logic              eof;
    logic [SUM_W-1:0]  frame_sum;
    logic              sum_valid;
    logic              busy;

    modport master (
        output IRAM_valid, IRAM_A, IRAM_D, done, scan_mode, pix_ready,
        input  pix_valid, pix_data, sol, eof, frame_sum, sum_valid, busy
    );

    modport slave (
        input  IRAM_valid, IRAM_A, IRAM_D, done, scan_mode, pix_ready,
        output pix_valid, pix_data, sol, eof, frame_sum, sum_valid, busy
    );

endinterface

// File: rtl/lcd_fbuf.sv
// 64x8 frame buffer: one write port, one synchronous read port (1-cycle latency).
// The read register holds its value when rd_en is low, which the scan-out uses for stalls.
module lcd_fbuf
    import lcd_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [PIX_W-1:0]  rd_data
);

    logic [PIX_W-1:0] mem [PIX_N];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/lcd_scanout.sv
// Captures a 64-pixel image, then streams it out in row- or column-major order
// over a valid/ready pixel bus and reports the sum of the transmitted pixels.
module lcd_scanout
    import lcd_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    lcd_scanout_if.slave bus,
    output lcd_state_t   state_dbg
);

    lcd_state_t        state, state_n;
    logic              done_q;
    logic              mode_q;
    logic [6:0]        rd_idx;
    logic              done_rise;
    logic              scan_start;
    logic              xfer;
    logic              advance;
    logic              rd_en;
    logic              wr_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [PIX_W-1:0]  rd_data;
    logic [SUM_W-1:0]  sum_q;
    logic              pix_valid_q;
    logic              sol_q;
    logic              eof_q;

    assign done_rise = bus.done & ~done_q;
    assign xfer      = pix_valid_q & bus.pix_ready;
    // The output slot may be refilled when empty or when its beat leaves this cycle.
    assign advance   = ~pix_valid_q | bus.pix_ready;
    assign rd_en     = (state == SCAN) & advance & ~rd_idx[6];
    assign rd_addr   = scan_addr(rd_idx[ADDR_W-1:0], mode_q);
    assign wr_en     = bus.IRAM_valid & ((state == IDLE) | (state == CAPTURE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        scan_start = 1'b0;
        case (state)
            IDLE: begin
                if (done_rise) begin
                    state_n    = SCAN;
                    scan_start = 1'b1;
                end else if (bus.IRAM_valid) begin
                    state_n = CAPTURE;
                end
            end
            CAPTURE: begin
                if (done_rise) begin
                    state_n    = SCAN;
                    scan_start = 1'b1;
                end
            end
            SCAN: begin
                if (xfer && eof_q) begin
                    state_n = REPORT;
                end
            end
            REPORT:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q <= 1'b0;
            mode_q <= 1'b0;
            sum_q  <= '0;
        end else begin
            done_q <= bus.done;
            if (scan_start) begin
                mode_q <= bus.scan_mode;
                sum_q  <= '0;
            end else if (xfer) begin
                sum_q <= sum_q + {{(SUM_W-PIX_W){1'b0}}, rd_data};
            end
        end
    end

    // rd_idx is the next scan index to fetch; 64 means the whole frame has been fetched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_idx      <= '0;
            pix_valid_q <= 1'b0;
            sol_q       <= 1'b0;
            eof_q       <= 1'b0;
        end else if (state != SCAN) begin
            rd_idx      <= '0;
            pix_valid_q <= 1'b0;
            sol_q       <= 1'b0;
            eof_q       <= 1'b0;
        end else if (advance) begin
            if (!rd_idx[6]) begin
                pix_valid_q <= 1'b1;
                sol_q       <= (rd_idx[2:0] == 3'd0);
                eof_q       <= (rd_idx[5:0] == 6'd63);
                rd_idx      <= rd_idx + 7'd1;
            end else begin
                pix_valid_q <= 1'b0;
                sol_q       <= 1'b0;
                eof_q       <= 1'b0;
            end
        end
    end

    lcd_fbuf u_fbuf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (bus.IRAM_A),
        .wr_data (bus.IRAM_D),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign bus.pix_valid = pix_valid_q;
    assign bus.pix_data  = rd_data;
    assign bus.sol       = sol_q;
    assign bus.eof       = eof_q;
    assign bus.frame_sum = sum_q;
    assign bus.sum_valid = (state == REPORT);
    assign bus.busy      = (state != IDLE);
    assign state_dbg     = state;

endmodule

// File: doc/lcd_scanout.md
LCD_SCANOUT -- requirements
Module: lcd_scanout

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all logic samples on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port IRAM_valid, input, 1, write strobe from the upstream image controller.
REQ-004 SHALL have port IRAM_A, input, 6, write address; index = row*8 + col.
REQ-005 SHALL have port IRAM_D, input, 8, write pixel data.
REQ-006 SHALL have port done, input, 1, upstream frame-complete level.
REQ-007 SHALL have port scan_mode, input, 1, scan order: 0 = row-major, 1 = column-major.
REQ-008 SHALL have port pix_ready, input, 1, downstream panel accept.
REQ-009 SHALL have port pix_valid, output, 1, pixel offered.
REQ-010 SHALL have port pix_data, output, 8, pixel value.
REQ-011 SHALL have port sol, output, 1, first pixel of a scan line; qualified by pix_valid.
REQ-012 SHALL have port eof, output, 1, last (64th) pixel of the frame; qualified by pix_valid.
REQ-013 SHALL have port frame_sum, output, 14, sum of the 64 transmitted pixels.
REQ-014 SHALL have port sum_valid, output, 1, one-cycle pulse marking frame_sum valid.
REQ-015 SHALL have port busy, output, 1, high outside IDLE.

Function
REQ-016 SHALL implement states IDLE, CAPTURE, SCAN, REPORT.
REQ-017 IDLE -> CAPTURE when IRAM_valid=1.
REQ-018 In IDLE and CAPTURE, every cycle with IRAM_valid=1 SHALL write IRAM_D to buffer[IRAM_A]; a later write to the same address overwrites the earlier one.
REQ-019 IDLE or CAPTURE -> SCAN on a rising edge of done, detected against a registered copy of done; a done level that stays high SHALL NOT retrigger.
REQ-020 scan_mode SHALL be sampled on the SCAN entry cycle and held for the whole frame.
REQ-021 Scan index k = 0..63: row-major reads buffer[k]; column-major reads buffer[(k%8)*8 + k/8].
REQ-022 pix_valid SHALL rise exactly 2 cycles after done rises, allowing 1 cycle of buffer read latency.
REQ-023 While pix_valid=1 and pix_ready=0, pix_data, sol and eof SHALL hold stable.
REQ-024 A transfer occurs on a cycle with pix_valid=1 and pix_ready=1; the next pixel SHALL be offered on the following cycle, giving 1 pixel/cycle throughput when ready is held high.
REQ-025 sol SHALL be 1 when k%8 = 0; eof SHALL be 1 when k = 63.
REQ-026 frame_sum SHALL accumulate each transferred pixel, unsigned and zero-extended; 14 bits is sufficient because 64*255 = 16320, so no overflow occurs.
REQ-027 The accumulator SHALL clear on SCAN entry; frame_sum SHALL hold its last value until the next SCAN entry.
REQ-028 After the eof transfer, pix_valid SHALL drop the next cycle, the FSM SHALL enter REPORT, and sum_valid SHALL pulse for exactly one cycle.
REQ-029 REPORT -> IDLE unconditionally after that one cycle.
REQ-030 IRAM_valid during SCAN or REPORT SHALL be ignored and the buffer left unchanged.
REQ-031 A done rising edge during SCAN or REPORT SHALL be ignored.

Reset
REQ-032 Reset SHALL put the FSM in IDLE and drive pix_valid=0, pix_data=0, sol=0, eof=0, frame_sum=0, sum_valid=0, busy=0.
REQ-033 Reset SHALL clear the scan index and the registered copy of done.
REQ-034 Buffer contents are unspecified after reset.
REQ-035 Reset asserted mid-SCAN SHALL abort the frame immediately, with no sum_valid pulse.

Structure
REQ-036 Shared package lcd_pkg SHALL hold the state encoding, IMG_W=8, PIX_N=64 and SUM_W=14.
REQ-037 The 64x8 storage SHALL be the sub-module lcd_fbuf: one write port and one synchronous read port with 1-cycle read latency.

Verification
REQ-038 Write buffer[i]=i for i=0..63, pulse done, scan_mode=0, pix_ready=1 -> pix_data 0,1,..,63 on consecutive cycles; sol at 0,8,..,56; eof at 63; frame_sum=2016 with a single sum_valid pulse.
REQ-039 Same image with scan_mode=1 -> sequence 0,8,16,..,56,1,9,..,63; frame_sum=2016.
REQ-040 All pixels 0xFF with pix_ready toggling randomly -> 64 transfers, data stable while stalled, frame_sum=16320.
REQ-041 Write address 5 first with 0x11, then with 0x22 -> the 6th pixel scanned is 0x22.
REQ-042 done held high for 100 cycles -> exactly one frame scanned; IRAM_valid pulses during SCAN leave the next frame's data unchanged.
REQ-043 Reset asserted at pixel 30 -> all outputs return to 0 and state is IDLE; a following capture-plus-done produces a complete frame.
